// File: rtl/gf180mcu_fd_sc_mcu7t5v0__celltest_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__celltest_pkg: shared state enum, vector field indices and golden cell functions
package gf180mcu_fd_sc_mcu7t5v0__celltest_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam int IDX_A1 = 0;
  localparam int IDX_A2 = 1;
  localparam int IDX_B1 = 2;
  localparam int IDX_B2 = 3;
  localparam int IDX_C  = 4;
  localparam logic [4:0] VEC_LAST = 5'd31;
  localparam logic [5:0] ERR_MAX  = 6'd63;
  function automatic logic golden_oai221(input logic [4:0] v);
    return !((v[IDX_A1] | v[IDX_A2]) & (v[IDX_B1] | v[IDX_B2]) & v[IDX_C]);
  endfunction
  function automatic logic golden_aoi221(input logic [4:0] v);
    return !((v[IDX_A1] & v[IDX_A2]) | (v[IDX_B1] & v[IDX_B2]) | v[IDX_C]);
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__misr.sv
// gf180mcu_fd_sc_mcu7t5v0__misr: Galois MISR; ports clk, rst_n (async low), clr, en, din -> sig
module gf180mcu_fd_sc_mcu7t5v0__misr #(
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ {{(SIG_W-1){1'b0}}, din};
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai221_tester.sv
// gf180mcu_fd_sc_mcu7t5v0__oai221_tester: exhaustive OAI221/AOI221 cell tester
// ports: CLK, RN (async low), START, MODE (0=OAI,1=AOI), ZN_IN <- cell; A1..C -> cell;
//        BUSY, DONE, PASS, ERR_CNT (sat 63), FIRST_ERR_VEC, SIG (MISR of sampled ZN_IN)
module gf180mcu_fd_sc_mcu7t5v0__oai221_tester
  import gf180mcu_fd_sc_mcu7t5v0__celltest_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int LOOPS = 1,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'hB400
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             MODE,
  input  logic             ZN_IN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [5:0]       ERR_CNT,
  output logic [4:0]       FIRST_ERR_VEC,
  output logic [SIG_W-1:0] SIG
);
  localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  state_t r_state, w_state_nxt;
  logic [4:0] r_vec, r_first;
  logic [LW-1:0] r_loop;
  logic [SW-1:0] r_settle;
  logic [5:0] r_err, w_err_nxt;
  logic r_mode, r_busy, r_done, r_pass;
  logic w_start, w_sample, w_golden, w_miss, w_last, w_settle_end;
  assign w_start = START && (r_state == S_IDLE || r_state == S_DONE);
  assign w_sample = r_state == S_SAMPLE;
  assign w_golden = r_mode ? golden_aoi221(r_vec) : golden_oai221(r_vec);
  assign w_miss = w_sample && (ZN_IN != w_golden);
  assign w_err_nxt = (w_miss && r_err != ERR_MAX) ? r_err + 6'd1 : r_err;
  assign w_last = r_vec == VEC_LAST && r_loop == LOOP_LAST;
  assign w_settle_end = r_settle == SETTLE_LAST;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_start ? S_SETTLE :
                  (r_state == S_SETTLE && w_settle_end) ? S_SAMPLE :
                  w_sample ? (w_last ? S_DONE : S_SETTLE) : r_state;
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      r_state <= S_IDLE;
      r_vec <= '0;
      r_loop <= '0;
      r_settle <= '0;
      r_mode <= 1'b0;
      r_err <= '0;
      r_first <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_mode <= MODE;
        r_vec <= '0;
        r_loop <= '0;
        r_settle <= '0;
        r_err <= '0;
        r_first <= '0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else if (r_state == S_SETTLE) begin
        r_settle <= w_settle_end ? '0 : r_settle + SW'(1);
      end else if (w_sample) begin
        r_err <= w_err_nxt;
        // a zero count (it never returns to zero once saturated) marks the first miss
        if (w_miss && r_err == '0) r_first <= r_vec;
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= w_err_nxt == '0;
        end else begin
          r_vec <= r_vec + 5'd1;
          if (r_vec == VEC_LAST) r_loop <= r_loop + LW'(1);
        end
      end
    end
  gf180mcu_fd_sc_mcu7t5v0__misr #(.SIG_W(SIG_W), .SIG_POLY(SIG_POLY)) u_misr (
    .clk(CLK), .rst_n(RN), .clr(w_start), .en(w_sample), .din(ZN_IN), .sig(SIG)
  );
  assign A1 = r_vec[IDX_A1];
  assign A2 = r_vec[IDX_A2];
  assign B1 = r_vec[IDX_B1];
  assign B2 = r_vec[IDX_B2];
  assign C = r_vec[IDX_C];
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign ERR_CNT = r_err;
  assign FIRST_ERR_VEC = r_first;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai221_tester.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__oai221_tester: scoreboard bench for the OAI221/AOI221 tester
module tb_gf180mcu_fd_sc_mcu7t5v0__oai221_tester;
  logic clk = 0, rn = 0, start = 0, start8 = 0, mode = 0;
  logic [1:0] zm = 0, zm8 = 1;
  logic a1, a2, b1, b2, c, busy, done, pass, zn;
  logic a1_8, a2_8, b1_8, b2_8, c_8, busy8, done8, pass8, zn8;
  logic [5:0] err, err8;
  logic [4:0] first, first8, pins, pins8;
  logic [15:0] sig, sig8;
  always #5 clk = ~clk;
  assign pins = {c, b2, b1, a2, a1};
  assign pins8 = {c_8, b2_8, b1_8, a2_8, a1_8};
  assign zn = (zm == 2'd0) ? ~((a1 | a2) & (b1 | b2) & c) : (zm == 2'd1);
  assign zn8 = (zm8 == 2'd0) ? ~((a1_8 | a2_8) & (b1_8 | b2_8) & c_8) : (zm8 == 2'd1);
  gf180mcu_fd_sc_mcu7t5v0__oai221_tester u_dut (
    .CLK(clk), .RN(rn), .START(start), .MODE(mode), .ZN_IN(zn),
    .A1(a1), .A2(a2), .B1(b1), .B2(b2), .C(c), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err), .FIRST_ERR_VEC(first), .SIG(sig)
  );
  gf180mcu_fd_sc_mcu7t5v0__oai221_tester #(.LOOPS(8)) u_dut8 (
    .CLK(clk), .RN(rn), .START(start8), .MODE(mode), .ZN_IN(zn8),
    .A1(a1_8), .A2(a2_8), .B1(b1_8), .B2(b2_8), .C(c_8), .BUSY(busy8), .DONE(done8), .PASS(pass8),
    .ERR_CNT(err8), .FIRST_ERR_VEC(first8), .SIG(sig8)
  );
  typedef struct {
    int cyc;
    logic [5:0] err;
    logic [4:0] first;
    logic pass;
    logic [15:0] sig;
  } res_t;
  res_t sb[$];
  int n_vec = 0, n_miss = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic res_t model(input logic [1:0] z_sel, input bit md, input int loops);
    res_t r;
    logic [4:0] v;
    logic oai, aoi, z, g;
    r.cyc = 32 * loops * 3;
    r.err = 0;
    r.first = 0;
    r.sig = 0;
    for (int l = 0; l < loops; l++)
      for (int i = 0; i < 32; i++) begin
        v = 5'(i);
        oai = ~((v[0] | v[1]) & (v[2] | v[3]) & v[4]);
        aoi = ~((v[0] & v[1]) | (v[2] & v[3]) | v[4]);
        z = (z_sel == 2'd0) ? oai : (z_sel == 2'd1);
        g = md ? aoi : oai;
        if (z != g) begin
          if (r.err == 0) r.first = v;
          if (r.err != 6'd63) r.err = r.err + 6'd1;
        end
        r.sig = {r.sig[14:0], 1'b0} ^ (r.sig[15] ? 16'hB400 : 16'h0) ^ {15'b0, z};
      end
    r.pass = r.err == 0;
    return r;
  endfunction
  task automatic run(input bit d8, input logic [1:0] z_sel, input bit md, input string tag);
    res_t e;
    int cyc;
    logic dn;
    sb.push_back(model(z_sel, md, d8 ? 8 : 1));
    @(negedge clk);
    mode = md;
    if (d8) begin zm8 = z_sel; start8 = 1; end
    else begin zm = z_sel; start = 1; end
    @(posedge clk);
    #1;
    chk({tag, "_start_busy"}, d8 ? busy8 : busy, 1);
    chk({tag, "_start_done"}, d8 ? done8 : done, 0);
    chk({tag, "_start_err"}, d8 ? err8 : err, 0);
    chk({tag, "_start_first"}, d8 ? first8 : first, 0);
    chk({tag, "_start_pins"}, d8 ? pins8 : pins, 0);
    start = 0;
    start8 = 0;
    cyc = 0;
    dn = 0;
    while (!dn && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      dn = d8 ? done8 : done;
      if (d8) start8 = (cyc >= 100 && cyc < 103) || cyc == 500;
      else start = cyc == 40;
    end
    start = 0;
    start8 = 0;
    e = sb.pop_front();
    chk({tag, "_cycles"}, cyc, e.cyc);
    chk({tag, "_done"}, dn, 1);
    chk({tag, "_busy"}, d8 ? busy8 : busy, 0);
    chk({tag, "_err"}, d8 ? err8 : err, e.err);
    chk({tag, "_first"}, d8 ? first8 : first, e.first);
    chk({tag, "_pass"}, d8 ? pass8 : pass, e.pass);
    chk({tag, "_sig"}, d8 ? sig8 : sig, e.sig);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_first", first, 0);
    chk("rst_sig", sig, 0);
    chk("rst_pins", pins, 0);
    rn = 1;
    run(0, 2'd0, 0, "ideal_oai");
    run(0, 2'd1, 0, "stuck1");
    run(0, 2'd0, 1, "aoi_golden");
    run(0, 2'd2, 0, "restart_stuck0");
    run(1, 2'd1, 0, "sat_loops8");
    @(negedge clk);
    mode = 0;
    zm = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (31) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_pins", pins, 10);
    #2 rn = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err", err, 0);
    chk("arst_first", first, 0);
    chk("arst_sig", sig, 0);
    chk("arst_pins", pins, 0);
    @(negedge clk);
    rn = 1;
    run(0, 2'd0, 0, "rerun_ideal");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
